// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the bubble instruction and the instruction size used for PC stepping.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with a one-entry hold buffer for a response that
// arrives while decode is stalled.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_write,
    input  logic                  i_load_rsp,
    input  logic                  i_load_hold,
    input  logic                  i_capture,
    input  logic [DAT_WIDTH-1:0]  i_rsp_data,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_pc4,
    output logic [DAT_WIDTH-1:0]  o_ins,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc4,
    output logic                  o_valid
);

    logic [DAT_WIDTH-1:0] r_buf;

    // Park a stalled response until decode can accept it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (i_capture) begin
            r_buf <= i_rsp_data;
        end
    end

    // IF/ID update: flush wins, then a delivered instruction, then a bubble
    // when writable; otherwise hold. Bubbles keep the PC fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ins   <= DAT_WIDTH'(NOP_INSTR);
            o_pc    <= '0;
            o_pc4   <= '0;
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_ins   <= DAT_WIDTH'(NOP_INSTR);
            o_valid <= 1'b0;
        end else if (i_load_rsp || i_load_hold) begin
            o_ins   <= i_load_rsp ? i_rsp_data : r_buf;
            o_pc    <= i_pc;
            o_pc4   <= i_pc4;
            o_valid <= 1'b1;
        end else if (i_write) begin
            o_ins   <= DAT_WIDTH'(NOP_INSTR);
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding-request memory FSM
// (REQ/WAIT/HOLD) and redirect handling. IF/ID lives in if_id_reg.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              ADDR_WIDTH = 32,
    parameter int              DAT_WIDTH  = 32,
    parameter [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PC_Write,
    input  logic                  IF_ID_Write,
    input  logic                  PCSrc_E,
    input  logic [ADDR_WIDTH-1:0] PC_Target_E,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DAT_WIDTH-1:0]  imem_rsp_data,
    output logic [DAT_WIDTH-1:0]  Ins_D,
    output logic [ADDR_WIDTH-1:0] PC_D,
    output logic [ADDR_WIDTH-1:0] PC_4D,
    output logic                  Valid_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    fetch_state_e          r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, r_req_pc, w_req_pc4;
    logic                  r_drop, w_drop_nxt;
    logic                  w_stall, w_hs;
    logic                  w_load_rsp, w_load_hold, w_capture;

    // Request outputs and control decode; valid is forced low during reset.
    always_comb begin
        imem_req_valid = rst_n && (r_state == REQ);
        imem_req_addr  = r_pc;
        w_stall        = !(PC_Write && IF_ID_Write);
        w_hs           = imem_req_valid && imem_req_ready;
        w_req_pc4      = r_req_pc + ADDR_WIDTH'(INSTR_BYTES);
        w_load_rsp     = (r_state == WAIT) && imem_rsp_valid && !r_drop && !PCSrc_E && !w_stall;
        w_capture      = (r_state == WAIT) && imem_rsp_valid && !r_drop && !PCSrc_E && w_stall;
        w_load_hold    = (r_state == HOLD) && !PCSrc_E && !w_stall;
    end

    // Next-state and drop-flag logic; a flush with a request in flight marks
    // its response for discard instead of cancelling the bus transaction.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            REQ: begin
                if (w_hs) begin
                    w_state_nxt = WAIT;
                    if (PCSrc_E) w_drop_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_drop || PCSrc_E) begin
                        w_state_nxt = REQ;
                        w_drop_nxt  = 1'b0;
                    end else if (w_stall) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end else if (PCSrc_E) begin
                    w_drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrc_E || !w_stall) w_state_nxt = REQ;
            end
            default: w_state_nxt = REQ;
        endcase
    end

    // State, drop flag and PC registers; redirect has priority on the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= REQ;
            r_drop   <= 1'b0;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (w_hs) r_req_pc <= r_pc;
            if (PCSrc_E) begin
                r_pc <= PC_Target_E;
            end else if (w_load_rsp || w_load_hold) begin
                r_pc <= w_req_pc4;
            end
        end
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DAT_WIDTH  (DAT_WIDTH)
    ) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (PCSrc_E),
        .i_write     (IF_ID_Write),
        .i_load_rsp  (w_load_rsp),
        .i_load_hold (w_load_hold),
        .i_capture   (w_capture),
        .i_rsp_data  (imem_rsp_data),
        .i_pc        (r_req_pc),
        .i_pc4       (w_req_pc4),
        .o_ins       (Ins_D),
        .o_pc        (PC_D),
        .o_pc4       (PC_4D),
        .o_valid     (Valid_D)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    // Count stalled cycles (HOLD, or WAIT without a response) and redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (PCSrc_E) r_flush_cnt <= r_flush_cnt + 32'd1;
            if ((r_state == HOLD) || ((r_state == WAIT) && !imem_rsp_valid))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // Drive the counter ports.
    always_comb begin
        stall_cnt = r_stall_cnt;
        flush_cnt = r_flush_cnt;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Each row gives one cycle's
// inputs and the outputs expected during that cycle (before its rising edge).
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PC_Write = 1'b1, IF_ID_Write = 1'b1, PCSrc_E = 1'b0;
    logic [31:0] PC_Target_E = '0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] Ins_D, PC_D, PC_4D;
    logic        Valid_D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .DAT_WIDTH  (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .PCSrc_E        (PCSrc_E),
        .PC_Target_E    (PC_Target_E),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .Ins_D          (Ins_D),
        .PC_D           (PC_D),
        .PC_4D          (PC_4D),
        .Valid_D        (Valid_D)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        pcw, ifw, fl;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] ea, eins, epc, epc4;
        logic        evld;
    } vec_t;

    localparam int NV = 26;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [31:0] NOP = 32'h0000_0013;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                                input logic pcw, input logic ifw, input logic fl,
                                input logic [31:0] tgt, input logic ev, input logic [31:0] ea,
                                input logic [31:0] eins, input logic [31:0] epc,
                                input logic [31:0] epc4, input logic evld);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.pcw = pcw; v.ifw = ifw;
        v.fl = fl; v.tgt = tgt; v.ev = ev; v.ea = ea; v.eins = eins;
        v.epc = epc; v.epc4 = epc4; v.evld = evld;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic vld);
        chk({tag, " Ins_D"}, Ins_D, ins);
        chk({tag, " PC_D"}, PC_D, pc);
        chk({tag, " PC_4D"}, PC_4D, pc4);
        chk({tag, " Valid_D"}, {31'b0, Valid_D}, {31'b0, vld});
    endtask

    initial begin
        //                rdy rv rdata          pcw ifw fl tgt            ev  addr           Ins            PC_D           PC_4D          V
        vecs[0]  = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0000, NOP,           32'h0,         32'h0,         F);
        vecs[1]  = mk(T, T, 32'h0050_0093,  T, T, F, 32'h0,          F, 32'h0000_0000, NOP,           32'h0,         32'h0,         F);
        vecs[2]  = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0004, 32'h0050_0093, 32'h0,         32'h4,         T);
        vecs[3]  = mk(T, T, 32'h1111_1111,  F, F, F, 32'h0,          F, 32'h0000_0004, NOP,           32'h0,         32'h4,         F);
        vecs[4]  = mk(T, F, 32'h0,          F, F, F, 32'h0,          F, 32'h0000_0004, NOP,           32'h0,         32'h4,         F);
        vecs[5]  = mk(T, F, 32'h0,          F, F, F, 32'h0,          F, 32'h0000_0004, NOP,           32'h0,         32'h4,         F);
        vecs[6]  = mk(T, F, 32'h0,          T, T, F, 32'h0,          F, 32'h0000_0004, NOP,           32'h0,         32'h4,         F);
        vecs[7]  = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0008, 32'h1111_1111, 32'h4,         32'h8,         T);
        vecs[8]  = mk(T, F, 32'h0,          T, T, T, 32'h100,        F, 32'h0000_0008, NOP,           32'h4,         32'h8,         F);
        vecs[9]  = mk(T, T, 32'hDEAD_BEEF,  T, T, F, 32'h0,          F, 32'h0000_0100, NOP,           32'h4,         32'h8,         F);
        vecs[10] = mk(F, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0100, NOP,           32'h4,         32'h8,         F);
        vecs[11] = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0100, NOP,           32'h4,         32'h8,         F);
        vecs[12] = mk(T, T, 32'h00A0_0113,  T, T, F, 32'h0,          F, 32'h0000_0100, NOP,           32'h4,         32'h8,         F);
        vecs[13] = mk(F, F, 32'h0,          F, F, T, 32'h200,        T, 32'h0000_0104, 32'h00A0_0113, 32'h100,       32'h104,       T);
        vecs[14] = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0200, NOP,           32'h100,       32'h104,       F);
        vecs[15] = mk(T, T, 32'h2222_2222,  T, F, F, 32'h0,          F, 32'h0000_0200, NOP,           32'h100,       32'h104,       F);
        vecs[16] = mk(T, F, 32'h0,          T, F, T, 32'hFFFF_FFFC,  F, 32'h0000_0200, NOP,           32'h100,       32'h104,       F);
        vecs[17] = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'hFFFF_FFFC, NOP,           32'h100,       32'h104,       F);
        vecs[18] = mk(T, T, 32'h3333_3333,  T, T, F, 32'h0,          F, 32'hFFFF_FFFC, NOP,           32'h100,       32'h104,       F);
        vecs[19] = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0000, 32'h3333_3333, 32'hFFFF_FFFC, 32'h0,         T);
        vecs[20] = mk(T, T, 32'h4444_4444,  T, T, T, 32'h40,         F, 32'h0000_0000, NOP,           32'hFFFF_FFFC, 32'h0,         F);
        vecs[21] = mk(T, F, 32'h0,          T, T, T, 32'h80,         T, 32'h0000_0040, NOP,           32'hFFFF_FFFC, 32'h0,         F);
        vecs[22] = mk(T, T, 32'h5555_5555,  T, T, F, 32'h0,          F, 32'h0000_0080, NOP,           32'hFFFF_FFFC, 32'h0,         F);
        vecs[23] = mk(T, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0080, NOP,           32'hFFFF_FFFC, 32'h0,         F);
        vecs[24] = mk(T, T, 32'h6666_6666,  T, T, F, 32'h0,          F, 32'h0000_0080, NOP,           32'hFFFF_FFFC, 32'h0,         F);
        vecs[25] = mk(F, F, 32'h0,          T, T, F, 32'h0,          T, 32'h0000_0084, 32'h6666_6666, 32'h80,        32'h84,        T);

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        #1;
        chk("reset req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk_ifid("reset", NOP, 32'h0, 32'h0, F);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n          = 1'b1;
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rv;
            imem_rsp_data  = vecs[i].rdata;
            PC_Write       = vecs[i].pcw;
            IF_ID_Write    = vecs[i].ifw;
            PCSrc_E        = vecs[i].fl;
            PC_Target_E    = vecs[i].tgt;
            #1;
            chk($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].ev});
            chk($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].ea);
            chk_ifid($sformatf("row%0d", i), vecs[i].eins, vecs[i].epc, vecs[i].epc4, vecs[i].evld);
        end

        // Row 25's edge loads a bubble into IF/ID.
        @(negedge clk);
        imem_req_ready = 1'b1;
        PCSrc_E = 1'b0;
        #1;
        chk_ifid("post-table", NOP, 32'h80, 32'h84, F);
`ifdef FETCH_PERF_CNT_EN
        chk("flush_cnt", flush_cnt, 32'd5);
        chk("stall_cnt", stall_cnt, 32'd5);
`endif

        // Reset in the middle of a request: handshake now, then reset in WAIT.
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk_ifid("midreset", NOP, 32'h0, 32'h0, F);
`ifdef FETCH_PERF_CNT_EN
        chk("midreset flush_cnt", flush_cnt, 32'd0);
        chk("midreset stall_cnt", stall_cnt, 32'd0);
`endif
        // The abandoned transaction's response shows up after release.
        @(negedge clk);
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h7777_7777;
        #1;
        chk("afterreset req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("afterreset req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1;
        chk_ifid("stale rsp ignored", NOP, 32'h0, 32'h0, F);
        chk("stale rsp req_valid", {31'b0, imem_req_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DAT_WIDTH, 32, instruction width; RESET_PC, 32'h0000_0000, first fetch address.
REQ-002 Ports SHALL be: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-003 Ports SHALL be: PC_Write  in  1  PC may advance; IF_ID_Write  in  1  IF/ID may load; PCSrc_E  in  1  redirect and flush; PC_Target_E  in  ADDR_WIDTH  redirect address.
REQ-004 Ports SHALL be: imem_req_valid  out  1; imem_req_ready  in  1; imem_req_addr  out  ADDR_WIDTH; imem_rsp_valid  in  1; imem_rsp_data  in  DAT_WIDTH.
REQ-005 Ports SHALL be: Ins_D  out  DAT_WIDTH; PC_D  out  ADDR_WIDTH; PC_4D  out  ADDR_WIDTH; Valid_D  out  1  IF/ID holds a real instruction.

Function
REQ-006 The FSM SHALL have the states REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-007 In REQ the block SHALL drive imem_req_valid=1 and imem_req_addr=pc_q, capture req_pc=pc_q on valid&&ready, and then go to WAIT.
REQ-008 In WAIT, when imem_rsp_valid=1 and PC_Write&&IF_ID_Write=1, the block SHALL load IF/ID with {imem_rsp_data, req_pc, req_pc+4} and Valid_D=1, set pc_q=req_pc+4, and go to REQ.
REQ-009 In WAIT, when imem_rsp_valid=1 and the stall is active, the block SHALL copy the response into a one-entry hold buffer and go to HOLD.
REQ-010 In HOLD, once PC_Write&&IF_ID_Write=1, the block SHALL load IF/ID from the hold buffer, set pc_q=req_pc+4, and go to REQ.
REQ-011 When IF_ID_Write=1 and no instruction is delivered that cycle, IF/ID SHALL load a bubble: Ins_D=32'h0000_0013, Valid_D=0, PC_D/PC_4D unchanged.
REQ-012 When IF_ID_Write=0, IF/ID SHALL hold its value, unless PCSrc_E=1.
REQ-013 PCSrc_E=1 SHALL have priority over every other input: pc_q<=PC_Target_E, and IF/ID<=bubble regardless of IF_ID_Write.
REQ-014 On flush in REQ without handshake, the next request SHALL use PC_Target_E; an address change while valid&&!ready is legal only on redirect.
REQ-015 On flush in REQ with handshake, and on flush in WAIT without a response, the block SHALL set drop=1; the next response SHALL then be discarded, drop cleared, and the FSM go to REQ.
REQ-016 On flush in WAIT coinciding with the response, and on flush in HOLD, the data SHALL be discarded and the FSM go to REQ.
REQ-017 PC arithmetic SHALL be modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-018 Latency SHALL be: request issued the cycle after entry to REQ; with zero-wait memory and no stalls, one instruction every 2 cycles.

Reset
REQ-019 While rst_n=0, the state SHALL be REQ, pc_q=RESET_PC, drop=0, Ins_D=32'h0000_0013, PC_D=0, PC_4D=0, Valid_D=0 and imem_req_valid=0.
REQ-020 An asserted rst_n mid-request SHALL abandon the transaction, and no response SHALL be accepted until a new request is issued.

Configuration
REQ-021 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt[31:0] (cycles in HOLD, or in WAIT with no response) and flush_cnt[31:0] (PCSrc_E cycles), both reset to 0 and wrapping at 2^32.
REQ-022 Without FETCH_PERF_CNT_EN, these ports and their logic SHALL be absent, with no other change in behaviour.

Structure
REQ-023 A shared package SHALL hold the fetch_state_e enum (REQ, WAIT, HOLD), NOP_INSTR=32'h0000_0013 and INSTR_BYTES=4.
REQ-024 The IF/ID register plus hold buffer SHALL be one sub-module, if_id_reg; the FSM and PC SHALL stay in fetch_stage.

Verification
REQ-025 Reset release with RESET_PC=0 and zero-wait memory returning 0x00500093 -> imem_req_addr=0 on the first cycle; Ins_D=0x00500093, PC_D=0, PC_4D=4, Valid_D=1 two cycles later.
REQ-026 IF_ID_Write=PC_Write=0 for 3 cycles while a response arrives -> FSM in HOLD and IF/ID unchanged; on release Ins_D=buffered word, and the next request address is PC+4.
REQ-027 PCSrc_E=1 with PC_Target_E=0x100 while in WAIT, response one cycle later -> response dropped, Valid_D=0, Ins_D=0x13, next imem_req_addr=0x100.
REQ-028 PCSrc_E=1 in the same cycle as IF_ID_Write=0 -> Ins_D=0x13 and Valid_D=0 regardless.
REQ-029 pc_q=0xFFFFFFFC fetch -> PC_4D=0x0 and next request address 0x0.
REQ-030 (FETCH_PERF_CNT_EN) 2 flushes and 5 stalled cycles -> flush_cnt=2, stall_cnt=5.
